// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed MULT (radix-2 Booth) / DIV (restoring) unit
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             bit_q, bit_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             divz_q, divz_d;

    logic [WIDTH:0]     mcand_x;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH+1:0] booth_shift;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [WIDTH-1:0]   a_mag, b_mag;

    // acc is one bit wider than WIDTH so acc - (-2^(WIDTH-1)) cannot overflow
    assign mcand_x     = {mcand_q[WIDTH-1], mcand_q};
    assign booth_sum   = (mq_q[0] & ~bit_q) ? acc_q - mcand_x :
                         (~mq_q[0] & bit_q) ? acc_q + mcand_x : acc_q;
    assign booth_shift = {booth_sum[WIDTH], booth_sum, mq_q};
    assign div_shift   = {acc_q[WIDTH-1:0], mq_q[WIDTH-1]};
    assign div_trial   = {1'b0, div_shift} - {2'b00, mcand_q};
    assign a_mag       = a[WIDTH-1] ? -a : a;
    assign b_mag       = b[WIDTH-1] ? -b : b;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mcand_d = mcand_q;
        bit_d   = bit_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        divz_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // The cycle carrying the done pulse is not yet open for a new start
                if (start && !done_q) begin
                    cnt_d  = '0;
                    acc_d  = '0;
                    bit_d  = 1'b0;
                    dz_d   = 1'b0;
                    negq_d = a[WIDTH-1] ^ b[WIDTH-1];
                    negr_d = a[WIDTH-1];
                    if (!op) begin
                        mq_d    = a;
                        mcand_d = b;
                        state_d = S_MULT;
                    end else if (b == '0) begin
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        mq_d    = a_mag;
                        mcand_d = b_mag;
                        state_d = S_DIV;
                    end
                end
            end
            S_MULT: begin
                acc_d = booth_shift[2*WIDTH+1:WIDTH+1];
                mq_d  = booth_shift[WIDTH:1];
                bit_d = booth_shift[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
            end
            S_DIV: begin
                acc_d = div_trial[WIDTH+1] ? div_shift : div_trial[WIDTH:0];
                mq_d  = {mq_q[WIDTH-2:0], ~div_trial[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (negq_q) mq_d = -mq_q;
                if (negr_q) acc_d = {1'b0, -acc_q[WIDTH-1:0]};
                state_d = S_DONE;
            end
            S_DONE: begin
                done_d = 1'b1;
                divz_d = dz_q;
                if (!dz_q) begin
                    hi_d = acc_q[WIDTH-1:0];
                    lo_d = mq_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_MULT) || (state_d == S_DIV) || (state_d == S_FIX);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            mcand_q <= '0;
            bit_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mcand_q <= mcand_d;
            bit_q   <= bit_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            divz_q  <= divz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = divz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          start_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                    chk({e.name, "_div_zero"}, 64'(div_zero), 64'(e.dz));
                    chk({e.name, "_latency"}, 64'(cyc - e.start_cyc), 64'(e.lat));
                end
            end else if (div_zero) begin
                chk("div_zero_without_done", 64'(div_zero), 64'd0);
            end
        end
    end

    task automatic issue(input string name, input logic o, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz, input int elat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        e.hi = ehi; e.lo = elo; e.dz = edz; e.lat = elat;
        e.start_cyc = cyc + 1;
        e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int busy_cycles);
        bit seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    int bc;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b1;

        issue("mult_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33);
        wait_done("mult_7_m3", bc);
        issue("mult_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33);
        wait_done("mult_min_min", bc);
        chk("mult_min_min_busy_cycles", 64'(bc), 64'd32);
        issue("mult_max_max", 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1, 1'b0, 33);
        wait_done("mult_max_max", bc);
        issue("mult_m1_m1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33);
        wait_done("mult_m1_m1", bc);

        issue("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
        wait_done("div_m7_2", bc);
        issue("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 34);
        wait_done("div_7_m2", bc);
        issue("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34);
        wait_done("div_overflow", bc);

        // 0x451 / 0x20 leaves hi=0x11, lo=0x22 for the divide-by-zero check
        issue("div_451_20", 1'b1, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0, 34);
        wait_done("div_451_20", bc);
        issue("div_by_zero", 1'b1, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1, 1);
        wait_done("div_by_zero", bc);

        issue("mult_ignore_start", 1'b0, 32'd1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FC18, 1'b0, 33);
        repeat (9) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("mult_ignore_start", bc);
        repeat (40) @(negedge clk);
        chk("done_count_after_ignore", 64'(n_done), 64'd10);

        issue("div_aborted", 1'b1, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0, 34);
        repeat (14) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        sb.delete();
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_div_zero", 64'(div_zero), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("done_count_after_abort", 64'(n_done), 64'd10);

        issue("mult_6_7", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33);
        wait_done("mult_6_7", bc);
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        chk("done_count_final", 64'(n_done), 64'd11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
